matmul4_sequencer: RTL
======================

# matmul4_sequencer

Sequencing stage that computes a full 4x4 fixed-point matrix product C = A·B using a single shared dot-product unit. On a start pulse it latches both operand matrices and presents one row of A and one column of B per cycle to the downstream coefficient unit, which is the existing 4-element multiply/add block. It then captures the returned coefficient into the result matrix. It sits between the Kalman update control FSM and the coefficient unit; 16 coefficients are produced per product.

## Interface
- N, 32, coefficient width in bits (signed fixed point; the fractional format is owned by the coefficient unit).
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a new product; sampled only when not busy.
- a_mat  in  16*N  operand A, element (r,c) at bits [(4r+c+1)N-1 : (4r+c)N].
- b_mat  in  16*N  operand B, same packing.
- vec_a  out  4*N  to coefficient unit: A(i,k) at bits [(k+1)N-1 : kN].
- vec_b  out  4*N  to coefficient unit: B(k,j) at bits [(k+1)N-1 : kN].
- coeff  in  N  dot product returned by coefficient unit.
- coeff_ovf  in  1  overflow flag returned by coefficient unit.
- c_mat  out  16*N  result C, same packing as a_mat; registered.
- busy  out  1  high while a product is in progress.
- done  out  1  one-cycle pulse when c_mat is complete.
- overflow  out  1  sticky OR of coeff_ovf over the current product.

## Operation
- States: IDLE, RUN, DONE; WAIT exists only with the pipe option enabled.
- Reset: state IDLE, idx=0, a_reg/b_reg=0, c_mat=0, busy=0, done=0, overflow=0.
- IDLE or DONE with start=1:
  - Latch a_mat/b_mat into a_reg/b_reg.
  - Clear overflow and set idx=0; c_mat keeps its old value until overwritten.
  - Go to RUN.
- IDLE with start=0: hold.
- DONE with start=0: go to IDLE.
- RUN:
  - idx (4-bit) maps to i=idx[3:2], j=idx[1:0].
  - vec_a is row i of a_reg; vec_b is column j of b_reg. Both are driven from registers only, with no combinational path from start or a_mat.
  - Each cycle, write coeff into c_mat element (i,j) and OR coeff_ovf into overflow.
  - idx increments each cycle. On idx=15, write and go to DONE (or to WAIT when piped).
- vec_a and vec_b are 0 outside RUN.
- start while busy=1 is ignored: no relatch, no restart.
- Operands changing after acceptance have no effect.
- reset mid-operation aborts immediately to the reset state. The partial c_mat is cleared.
- Element order is row-major: (0,0),(0,1),…,(3,3).

## Timing
- Edge E0: start sampled high. busy=1 from E0 until E16.
- Coefficient k is written to c_mat at edge E(k+1), k=0..15.
- done=1 and busy=0 in the cycle following E16; c_mat is final at that point.
- overflow is valid with done and holds until the next accepted start.
- A start sampled during the done cycle is accepted (back-to-back products). That gives a 17-cycle throughput per product without the pipe option.
- The coefficient unit is treated as combinational: coeff must settle within one cycle of vec_a/vec_b.

## Configuration
- MATMUL_SEQ_PIPE_EN defined:
  - coeff and coeff_ovf are registered once inside this block before capture.
  - Element k is written at E(k+2).
  - The WAIT state absorbs the final element, so busy covers E0..E17 and done asserts after E17 (18-cycle throughput).
- MATMUL_SEQ_PIPE_EN undefined: direct capture, timing as above, and the WAIT state is absent.

## Test plan
- Identity × M: A=I (diagonal 0x00040000 at Q=18), B=M with distinct elements. Required: c_mat=M, done exactly once, 16 cycles after start (17 when piped), overflow=0.
- Ordering: a bench coefficient model returns coeff=16·i+j. Required: c_mat element (i,j) equals 16·i+j, and vec_a/vec_b match row i and column j on each RUN cycle.
- Overflow: coeff_ovf=1 only while idx=9. Required: overflow=1 at done; overflow=0 after the next start with clean data.
- start pulsed at E5 and E10 while busy, with changed a_mat. Required: ignored; result matches the original operands and there is a single done.
- Back-to-back: start held high through the done cycle with new operands. Required: second product begins at once and completes 17 cycles later with correct values.
- reset asserted at E7 for one cycle. Required: busy=0, c_mat=0, no done. A following start yields a correct full product.

Source files
------------

// File: rtl/matmul4_sequencer.sv
// Sequences a 4x4 matrix product C = A*B through one shared dot-product unit, one element/cycle.
// Optional MATMUL_SEQ_PIPE_EN registers coeff/coeff_ovf before capture and adds a WAIT state.
module matmul4_sequencer #(
  parameter int unsigned N = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [16*N-1:0] a_mat,
  input  logic [16*N-1:0] b_mat,
  output logic [4*N-1:0]  vec_a,
  output logic [4*N-1:0]  vec_b,
  input  logic [N-1:0]    coeff,
  input  logic            coeff_ovf,
  output logic [16*N-1:0] c_mat,
  output logic            busy,
  output logic            done,
  output logic            overflow
);

`ifdef MATMUL_SEQ_PIPE_EN
  typedef enum logic [1:0] {StIdle, StRun, StWait, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
`endif

  state_e            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [16*N-1:0]   a_reg_q, a_reg_d;
  logic [16*N-1:0]   b_reg_q, b_reg_d;
  logic [16*N-1:0]   c_mat_q, c_mat_d;
  logic              ovf_q, ovf_d;

  logic              wr_en;
  logic [3:0]        wr_idx;
  logic [N-1:0]      wr_data;
  logic              wr_ovf;

`ifdef MATMUL_SEQ_PIPE_EN
  // Capture stage: the element index travels with its coefficient.
  logic [N-1:0] cap_q;
  logic         cap_ovf_q;
  logic [3:0]   cap_idx_q;
  logic         cap_vld_q;
  logic [N-1:0] cap_d;
  logic         cap_ovf_d;
  logic [3:0]   cap_idx_d;
  logic         cap_vld_d;

  always_comb begin
    cap_d     = coeff;
    cap_ovf_d = coeff_ovf;
    cap_idx_d = idx_q;
    cap_vld_d = (state_q == StRun);
    wr_en     = cap_vld_q;
    wr_idx    = cap_idx_q;
    wr_data   = cap_q;
    wr_ovf    = cap_ovf_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_q     <= '0;
      cap_ovf_q <= 1'b0;
      cap_idx_q <= '0;
      cap_vld_q <= 1'b0;
    end else begin
      cap_q     <= cap_d;
      cap_ovf_q <= cap_ovf_d;
      cap_idx_q <= cap_idx_d;
      cap_vld_q <= cap_vld_d;
    end
  end
`else
  always_comb begin
    wr_en   = (state_q == StRun);
    wr_idx  = idx_q;
    wr_data = coeff;
    wr_ovf  = coeff_ovf;
  end
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_reg_d = a_reg_q;
    b_reg_d = b_reg_q;
    c_mat_d = c_mat_q;
    ovf_d   = ovf_q;

    if (wr_en) begin
      c_mat_d[32'(wr_idx) * N +: N] = wr_data;
      ovf_d = ovf_q | wr_ovf;
    end

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_reg_d = a_mat;
          b_reg_d = b_mat;
          ovf_d   = 1'b0;
          idx_d   = '0;
          state_d = StRun;
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
      StRun: begin
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
`ifdef MATMUL_SEQ_PIPE_EN
          state_d = StWait;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef MATMUL_SEQ_PIPE_EN
      StWait: state_d = StDone;
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_reg_q <= '0;
      b_reg_q <= '0;
      c_mat_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_reg_q <= a_reg_d;
      b_reg_q <= b_reg_d;
      c_mat_q <= c_mat_d;
      ovf_q   <= ovf_d;
    end
  end

  // Operand vectors come only from latched registers, never from the live inputs.
  always_comb begin
    vec_a = '0;
    vec_b = '0;
    if (state_q == StRun) begin
      vec_a = a_reg_q[32'(idx_q[3:2]) * 4 * N +: 4 * N];
      for (int k = 0; k < 4; k++) begin
        vec_b[k*N +: N] = b_reg_q[(4 * k + 32'(idx_q[1:0])) * N +: N];
      end
    end
  end

`ifdef MATMUL_SEQ_PIPE_EN
  assign busy = (state_q == StRun) || (state_q == StWait);
`else
  assign busy = (state_q == StRun);
`endif
  assign done     = (state_q == StDone);
  assign c_mat    = c_mat_q;
  assign overflow = ovf_q;

endmodule
